// File: rtl/store_align_buffer.sv
// store_align_buffer
//   Store buffer that sits between the MEM stage and data memory. Stores
//   (sw/sh/sb) are lane-aligned into a 32-bit word with byte enables and
//   queued in a DEPTH-entry FIFO, then drained to memory one entry per
//   accepted MemReady. Misaligned stores are rejected with a one-cycle
//   MisalignErr pulse. Loads can probe the buffer for a same-word hazard.
//
// Ports
//   Clk, Reset                   clock, synchronous active-high reset
//   MemWrite[1:0]                store type: 0 none, 1 sw, 2 sb, 3 sh
//   Address, WriteDataIN         store byte address and register data
//   StoreReady, StoreStall       buffer not full / store blocked this cycle
//   MisalignErr                  registered pulse for a rejected store
//   LoadCheck, LoadAddress       load probe in MEM stage
//   LoadHazard                   load word matches a buffered store
//   MemValid, MemAddr, MemData,
//   MemByteEn, MemReady          head entry handshake towards memory
//   Count                        number of buffered entries
module store_align_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [1:0]                 MemWrite,
  input  logic [ADDR_W-1:0]          Address,
  input  logic [31:0]                WriteDataIN,
  output logic                       StoreReady,
  output logic                       StoreStall,
  output logic                       MisalignErr,
  input  logic                       LoadCheck,
  input  logic [ADDR_W-1:0]          LoadAddress,
  output logic                       LoadHazard,
  output logic                       MemValid,
  output logic [ADDR_W-1:0]          MemAddr,
  output logic [31:0]                MemData,
  output logic [3:0]                 MemByteEn,
  input  logic                       MemReady,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_WORD = 2'd1,
    ST_BYTE = 2'd2,
    ST_HALF = 2'd3
  } store_t;

  store_t st;

  logic [ADDR_W-3:0] ent_addr [DEPTH];
  logic [31:0]       ent_data [DEPTH];
  logic [3:0]        ent_be   [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;

  logic [1:0]        off;
  logic [1:0]        lane;
  logic              half_hi;
  logic              aligned;
  logic [31:0]       fmt_data;
  logic [3:0]        fmt_be;
  logic              push;
  logic              pop;
  logic              misalign;
  logic              hit;
  logic              unused_load_off;

  assign st  = store_t'(MemWrite);
  assign off = Address[1:0];

  // Big-endian: lowest byte address lives in the most significant lane.
  assign lane    = (BIG_ENDIAN != 0) ? ~off : off;
  assign half_hi = (BIG_ENDIAN != 0) ? ~off[1] : off[1];

  always_comb begin
    aligned  = 1'b0;
    fmt_data = '0;
    fmt_be   = '0;
    unique case (st)
      ST_WORD: begin
        aligned  = (off == 2'b00);
        fmt_data = WriteDataIN;
        fmt_be   = 4'b1111;
      end
      ST_BYTE: begin
        aligned  = 1'b1;
        fmt_data = {24'h0, WriteDataIN[7:0]} << {lane, 3'b000};
        fmt_be   = 4'b0001 << lane;
      end
      ST_HALF: begin
        aligned  = ~off[0];
        fmt_data = half_hi ? {WriteDataIN[15:0], 16'h0} : {16'h0, WriteDataIN[15:0]};
        fmt_be   = half_hi ? 4'b1100 : 4'b0011;
      end
      default: begin
        aligned  = 1'b0;
        fmt_data = '0;
        fmt_be   = '0;
      end
    endcase
  end

  assign StoreReady = (count_q < CW'(DEPTH));
  assign StoreStall = (st != ST_NONE) && !StoreReady;
  assign MemValid   = (count_q != '0);
  assign Count      = count_q;

  // A stalled store is ignored entirely, so it cannot raise MisalignErr.
  assign push     = (st != ST_NONE) && StoreReady && aligned;
  assign misalign = (st != ST_NONE) && StoreReady && !aligned;
  assign pop      = MemValid && MemReady;

  assign MemAddr   = {ent_addr[rd_ptr], 2'b00};
  assign MemData   = ent_data[rd_ptr];
  assign MemByteEn = ent_be[rd_ptr];

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (ent_addr[i] == LoadAddress[ADDR_W-1:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign LoadHazard      = LoadCheck && hit;
  assign unused_load_off = ^LoadAddress[1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      valid       <= '0;
      MisalignErr <= 1'b0;
    end else begin
      MisalignErr <= misalign;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload needs no reset; occupancy is tracked by valid/count.
  always_ff @(posedge Clk) begin
    if (!Reset && push) begin
      ent_addr[wr_ptr] <= Address[ADDR_W-1:2];
      ent_data[wr_ptr] <= fmt_data;
      ent_be[wr_ptr]   <= fmt_be;
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
module tb_store_align_buffer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteDataIN;
  logic        StoreReady;
  logic        StoreStall;
  logic        MisalignErr;
  logic        LoadCheck;
  logic [31:0] LoadAddress;
  logic        LoadHazard;
  logic        MemValid;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic [3:0]  MemByteEn;
  logic        MemReady;
  logic [2:0]  Count;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  store_align_buffer #(.DEPTH(4), .ADDR_W(32), .BIG_ENDIAN(1)) dut (
    .Clk(Clk), .Reset(Reset), .MemWrite(MemWrite), .Address(Address),
    .WriteDataIN(WriteDataIN), .StoreReady(StoreReady), .StoreStall(StoreStall),
    .MisalignErr(MisalignErr), .LoadCheck(LoadCheck), .LoadAddress(LoadAddress),
    .LoadHazard(LoadHazard), .MemValid(MemValid), .MemAddr(MemAddr),
    .MemData(MemData), .MemByteEn(MemByteEn), .MemReady(MemReady), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic store(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
    MemWrite = mw; Address = a; WriteDataIN = d;
    step();
    MemWrite = 2'd0;
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    chk({tag, "_valid"}, 64'(MemValid), 64'(1'b1));
    chk({tag, "_addr"}, 64'(MemAddr), 64'(a));
    chk({tag, "_data"}, 64'(MemData), 64'(d));
    chk({tag, "_be"}, 64'(MemByteEn), 64'(be));
  endtask

  task automatic pop_one();
    MemReady = 1'b1;
    step();
    MemReady = 1'b0;
    #1;
  endtask

  initial begin
    Reset = 1'b1; MemWrite = 2'd0; Address = '0; WriteDataIN = '0;
    LoadCheck = 1'b0; LoadAddress = '0; MemReady = 1'b0;
    step();
    step();
    Reset = 1'b0;
    #1;
    chk("rst_count", 64'(Count), 64'(0));
    chk("rst_valid", 64'(MemValid), 64'(0));
    chk("rst_ready", 64'(StoreReady), 64'(1));
    chk("rst_misal", 64'(MisalignErr), 64'(0));

    // Lane placement, big-endian
    store(2'd2, 32'h1003, 32'hFFFF_FFAB);
    chk("sb3_count", 64'(Count), 64'(1));
    head("sb3", 32'h1000, 32'h0000_00AB, 4'b0001);
    pop_one();
    chk("sb3_drained", 64'(Count), 64'(0));
    store(2'd2, 32'h1000, 32'h0000_00AB);
    head("sb0", 32'h1000, 32'hAB00_0000, 4'b1000);
    pop_one();
    store(2'd3, 32'h2002, 32'hFFFF_1234);
    head("sh2", 32'h2000, 32'h0000_1234, 4'b0011);
    pop_one();
    store(2'd3, 32'h2000, 32'hFFFF_1234);
    head("sh0", 32'h2000, 32'h1234_0000, 4'b1100);
    pop_one();
    store(2'd1, 32'h2004, 32'hDEAD_BEEF);
    head("sw", 32'h2004, 32'hDEAD_BEEF, 4'b1111);
    pop_one();

    // Misaligned stores
    store(2'd3, 32'h2001, 32'h0000_1234);
    chk("sh1_misal", 64'(MisalignErr), 64'(1));
    chk("sh1_count", 64'(Count), 64'(0));
    step();
    chk("sh1_pulse_end", 64'(MisalignErr), 64'(0));
    store(2'd1, 32'h2002, 32'h1111_1111);
    chk("sw2_misal", 64'(MisalignErr), 64'(1));
    chk("sw2_count", 64'(Count), 64'(0));

    // Fill to full, then drain with a held fifth store
    for (int k = 1; k <= 4; k++) store(2'd1, 32'h4000 + 32'(4 * k), 32'(k));
    chk("full_count", 64'(Count), 64'(4));
    chk("full_ready", 64'(StoreReady), 64'(0));
    MemWrite = 2'd1; Address = 32'h4014; WriteDataIN = 32'd5;
    #1;
    chk("full_stall", 64'(StoreStall), 64'(1));
    step();
    chk("full_stall_count", 64'(Count), 64'(4));
    MemReady = 1'b1;
    #1;
    chk("full_nobypass", 64'(StoreReady), 64'(0));
    head("drain1", 32'h4004, 32'd1, 4'b1111);
    step();
    chk("drain1_count", 64'(Count), 64'(3));
    chk("drain1_stall", 64'(StoreStall), 64'(0));
    head("drain2", 32'h4008, 32'd2, 4'b1111);
    step();
    MemWrite = 2'd0;
    chk("drain2_count", 64'(Count), 64'(3));
    for (int k = 3; k <= 5; k++) begin
      #1;
      head($sformatf("drain%0d", k), 32'h4000 + 32'(4 * k), 32'(k), 4'b1111);
      step();
    end
    MemReady = 1'b0;
    #1;
    chk("drain_empty_count", 64'(Count), 64'(0));
    chk("drain_empty_valid", 64'(MemValid), 64'(0));

    // Steady state at Count=2 with push+pop every cycle; pointers wrap
    store(2'd1, 32'h5000, 32'hA0);
    store(2'd1, 32'h5004, 32'hA1);
    for (int i = 0; i < 10; i++) begin
      MemWrite = 2'd1; Address = 32'h5000 + 32'(4 * (i + 2)); WriteDataIN = 32'hA0 + 32'(i + 2);
      MemReady = 1'b1;
      #1;
      chk($sformatf("pp%0d_data", i), 64'(MemData), 64'(32'hA0 + 32'(i)));
      step();
      chk($sformatf("pp%0d_count", i), 64'(Count), 64'(2));
    end
    MemWrite = 2'd0;
    #1;
    head("pp_tail0", 32'h5028, 32'hAA, 4'b1111);
    step();
    head("pp_tail1", 32'h502C, 32'hAB, 4'b1111);
    step();
    MemReady = 1'b0;
    #1;
    chk("pp_empty", 64'(Count), 64'(0));

    // Load hazard
    store(2'd2, 32'h3001, 32'h0000_00CD);
    LoadCheck = 1'b1; LoadAddress = 32'h3002;
    #1;
    chk("hz_match", 64'(LoadHazard), 64'(1));
    LoadAddress = 32'h3004;
    #1;
    chk("hz_other", 64'(LoadHazard), 64'(0));
    LoadCheck = 1'b0; LoadAddress = 32'h3002;
    #1;
    chk("hz_nocheck", 64'(LoadHazard), 64'(0));
    LoadCheck = 1'b1; MemReady = 1'b1;
    #1;
    chk("hz_popping", 64'(LoadHazard), 64'(1));
    step();
    MemReady = 1'b0;
    #1;
    chk("hz_drained", 64'(LoadHazard), 64'(0));
    LoadCheck = 1'b0;

    // Reset mid-drain beats push/pop/misalign
    for (int k = 0; k < 3; k++) store(2'd1, 32'h6000 + 32'(4 * k), 32'(k));
    chk("prerst_count", 64'(Count), 64'(3));
    Reset = 1'b1; MemReady = 1'b1; MemWrite = 2'd3; Address = 32'h6001;
    step();
    chk("rst2_count", 64'(Count), 64'(0));
    chk("rst2_valid", 64'(MemValid), 64'(0));
    chk("rst2_misal", 64'(MisalignErr), 64'(0));
    chk("rst2_ready", 64'(StoreReady), 64'(1));
    Reset = 1'b0; MemWrite = 2'd0;
    step();
    chk("postrst_valid", 64'(MemValid), 64'(0));
    chk("postrst_count", 64'(Count), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/store_align_buffer.md
STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning buffer entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 Parameter BIG_ENDIAN, default 1, meaning 1 selects MIPS big-endian lane order and 0 selects little-endian.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 MemWrite  input  2  store type: 0 none, 1 word (sw), 2 byte (sb), 3 half (sh).
REQ-007 Address  input  ADDR_W  store byte address.
REQ-008 WriteDataIN  input  32  register data; sb uses [7:0], sh uses [15:0].
REQ-009 StoreReady  output  1  buffer can accept a store (not full).
REQ-010 StoreStall  output  1  combinational: MemWrite!=0 and StoreReady=0.
REQ-011 MisalignErr  output  1  registered one-cycle pulse for a rejected misaligned store.
REQ-012 LoadCheck  input  1  a load is in the MEM stage this cycle.
REQ-013 LoadAddress  input  ADDR_W  byte address of that load.
REQ-014 LoadHazard  output  1  combinational: the load word matches a buffered store.
REQ-015 MemValid  output  1  head entry is presented to memory.
REQ-016 MemAddr  output  ADDR_W  head word address, bits [1:0] always 0.
REQ-017 MemData  output  32  head lane-aligned data.
REQ-018 MemByteEn  output  4  head byte enables, bit k = bits [8k+7:8k].
REQ-019 MemReady  input  1  memory accepts the head this cycle.
REQ-020 Count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-021 Push SHALL occur on an edge where MemWrite!=0, StoreReady=1, the store is aligned and Reset=0.
REQ-022 Alignment SHALL be: word needs Address[1:0]=0, half needs Address[0]=0, byte is always aligned.
REQ-023 A misaligned store SHALL NOT be enqueued, SHALL raise MisalignErr for exactly the following cycle, and SHALL leave Count unchanged.
REQ-024 Lane placement: offset o=Address[1:0], lane L=3-o if BIG_ENDIAN else o; a byte SHALL place data in lane L with ByteEn=1<<L.
REQ-025 A half at offset o SHALL occupy lanes {L,L-1} for big-endian (o=0: 4'b1100, o=2: 4'b0011) or {L,L+1} for little-endian (o=0: 4'b0011, o=2: 4'b1100), with MSB in the lower address when BIG_ENDIAN.
REQ-026 A word SHALL have ByteEn=4'b1111 and data unchanged; all disabled lanes SHALL be zero.
REQ-027 Stored MemAddr SHALL be {Address[ADDR_W-1:2],2'b00}.
REQ-028 MemValid SHALL be Count!=0 and registered; an entry pushed at edge N SHALL be visible at MemValid after edge N, with no same-cycle bypass.
REQ-029 Pop SHALL occur on an edge with MemValid=1 and MemReady=1; MemAddr/MemData/MemByteEn SHALL be stable while MemValid=1 and MemReady=0.
REQ-030 StoreReady SHALL be Count<DEPTH; when full, StoreReady=0 even if a pop occurs the same cycle (no full-bypass).
REQ-031 On simultaneous push and pop with 0<Count<DEPTH, Count SHALL be unchanged and order SHALL be preserved (FIFO).
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.
REQ-033 A store presented while StoreStall=1 SHALL be ignored; upstream holds it.
REQ-034 LoadHazard SHALL be LoadCheck and (some valid entry word address == LoadAddress[ADDR_W-1:2]), evaluated over stored entries only, including the head being popped that cycle.

Reset
REQ-035 On an edge with Reset=1: Count=0, both pointers=0, MemValid=0, MisalignErr=0, StoreReady=1; entry contents are don't-care.
REQ-036 Reset SHALL take priority over a simultaneous push, pop or misalign; pending entries SHALL be discarded mid-drain.

Verification
REQ-037 BIG_ENDIAN=1, sb Address=0x1003 data=0xAB -> MemAddr=0x1000, MemData=0x000000AB, MemByteEn=0001; sb at 0x1000 -> 0xAB000000 / 1000.
REQ-038 BIG_ENDIAN=1, sh 0x2002 data=0x1234 -> MemData=0x00001234 / 0011; sw 0x2004 data=0xDEADBEEF -> 1111; sh 0x2001 -> MisalignErr pulse, Count unchanged.
REQ-039 DEPTH=4, MemReady=0, five sw -> Count=4, StoreReady=0, StoreStall=1 on the fifth; then MemReady=1 -> four entries drain in order, one per cycle.
REQ-040 Count=2 with simultaneous push and pop over 10 cycles -> Count stays 2; pointer wrap verified; output order matches input order.
REQ-041 Buffered sb at 0x3001, LoadCheck=1 LoadAddress=0x3002 -> LoadHazard=1; LoadAddress=0x3004 -> 0; after drain -> 0.
REQ-042 Reset asserted with Count=3 and MemReady=1 -> after the edge Count=0, MemValid=0, no further memory writes.
